// File: rtl/pic_pkg.sv
// Shared 8259A PIC definitions: OCW2 command codes, the level type and
// a lowest-set-bit encoder used wherever a grant vector becomes a level.
package pic_pkg;

    typedef logic [2:0] level_t;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    // Index of the lowest set bit; 7 when the vector is empty.
    function automatic level_t lsb_index(input logic [7:0] v);
        level_t idx;
        logic   found;
        idx   = 3'd7;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = level_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/isr_priority_scan.sv
// Rotating find-first-set: scans from (lowest_priority+1) mod 8 upward,
// wrapping, and reports the first set bit.
module isr_priority_scan
    import pic_pkg::*;
(
    input  logic [7:0] bits_i,
    input  level_t     lowest_priority_i,
    output level_t     level_o,
    output logic       valid_o
);

    always_comb begin
        logic found;
        level_t idx;
        found   = 1'b0;
        level_o = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = lowest_priority_i + 3'd1 + level_t'(i);
            if (bits_i[idx] && !found) begin
                level_o = idx;
                found   = 1'b1;
            end
        end
        valid_o = |bits_i;
    end

endmodule

// File: rtl/in_service_register.sv
// 8259A In-Service Register: captures grants on INTA_1, clears on EOI
// (OCW2) or AEOI on INTA_2, and keeps the rotating-priority state.
module in_service_register
    import pic_pkg::*;
#(
    parameter level_t     RESET_LOWEST = 3'd7,
    parameter logic [2:0] RESET_ROTATE = 3'b010
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       INTA_1,
    input  logic       INTA_2,
    input  logic [7:0] ISR_IRR,
    input  logic       AEOI,
    input  logic       OCW2_WR,
    input  logic [2:0] OCW2_CMD,
    input  logic [2:0] OCW2_L,
    output logic [7:0] ISR,
    output logic [2:0] Rotate,
    output logic [2:0] lowest_priority,
    output logic [2:0] highest_in_service,
    output logic       in_service_valid,
    output logic [2:0] vector_level,
    output logic       spurious
);

    logic [7:0] isr_q, isr_d;
    logic [2:0] rotate_q, rotate_d;
    level_t     lowest_q, lowest_d;
    level_t     vector_q, vector_d;
    logic       spurious_q, spurious_d;

    level_t     hs_level;
    logic       hs_valid;

    isr_priority_scan u_scan (
        .bits_i            (isr_q),
        .lowest_priority_i (lowest_q),
        .level_o           (hs_level),
        .valid_o           (hs_valid)
    );

    logic       aeoi_strobe;
    logic [7:0] set_mask, clr_ocw, clr_aeoi;
    level_t     grant_level;

    // INTA_2 coinciding with INTA_1 is a protocol error and is dropped.
    assign aeoi_strobe = INTA_2 && !INTA_1 && AEOI;
    assign grant_level = lsb_index(ISR_IRR);

    always_comb begin
        set_mask   = '0;
        clr_ocw    = '0;
        clr_aeoi   = '0;
        vector_d   = vector_q;
        spurious_d = spurious_q;
        lowest_d   = lowest_q;
        rotate_d   = rotate_q;

        if (INTA_1) begin
            vector_d   = grant_level;
            spurious_d = (ISR_IRR == 8'h00);
            if (ISR_IRR != 8'h00)
                set_mask[grant_level] = 1'b1;
        end

        if (aeoi_strobe) begin
            if (!spurious_q)
                clr_aeoi[vector_q] = 1'b1;
            if (rotate_q == OCW2_ROT_AEOI_SET)
                lowest_d = vector_q;
        end

        // OCW2 decode after AEOI so its lowest_priority write takes precedence.
        if (OCW2_WR) begin
            case (OCW2_CMD)
                OCW2_NS_EOI: begin
                    if (hs_valid) clr_ocw[hs_level] = 1'b1;
                end
                OCW2_ROT_NS_EOI: begin
                    if (hs_valid) begin
                        clr_ocw[hs_level] = 1'b1;
                        lowest_d          = hs_level;
                    end
                end
                OCW2_SP_EOI: clr_ocw[OCW2_L] = 1'b1;
                OCW2_ROT_SP_EOI: begin
                    clr_ocw[OCW2_L] = 1'b1;
                    lowest_d        = OCW2_L;
                end
                OCW2_SET_PRI: lowest_d = OCW2_L;
                default: ;
            endcase
            if (OCW2_CMD == OCW2_ROT_NS_EOI || OCW2_CMD == OCW2_ROT_AEOI_SET ||
                OCW2_CMD == OCW2_ROT_SP_EOI || OCW2_CMD == OCW2_ROT_AEOI_CLR)
                rotate_d = OCW2_CMD;
        end

        isr_d = (isr_q & ~(clr_ocw | clr_aeoi)) | set_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_q      <= '0;
            rotate_q   <= RESET_ROTATE;
            lowest_q   <= RESET_LOWEST;
            vector_q   <= 3'd7;
            spurious_q <= 1'b0;
        end else begin
            isr_q      <= isr_d;
            rotate_q   <= rotate_d;
            lowest_q   <= lowest_d;
            vector_q   <= vector_d;
            spurious_q <= spurious_d;
        end
    end

    assign ISR                = isr_q;
    assign Rotate             = rotate_q;
    assign lowest_priority    = lowest_q;
    assign vector_level       = vector_q;
    assign spurious           = spurious_q;
    assign highest_in_service = hs_level;
    assign in_service_valid   = hs_valid;

endmodule

// File: tb/tb_in_service_register.sv
// Directed bench for in_service_register with hand-computed expectations.
module tb_in_service_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA_1, INTA_2, AEOI, OCW2_WR;
    logic [7:0] ISR_IRR;
    logic [2:0] OCW2_CMD, OCW2_L;
    logic [7:0] ISR;
    logic [2:0] Rotate, lowest_priority, highest_in_service, vector_level;
    logic       in_service_valid, spurious;

    int vectors = 0;
    int miscompares = 0;

    in_service_register #(.RESET_LOWEST(3'd7), .RESET_ROTATE(3'b010)) dut (
        .clk                (clk),
        .reset              (reset),
        .INTA_1             (INTA_1),
        .INTA_2             (INTA_2),
        .ISR_IRR            (ISR_IRR),
        .AEOI               (AEOI),
        .OCW2_WR            (OCW2_WR),
        .OCW2_CMD           (OCW2_CMD),
        .OCW2_L             (OCW2_L),
        .ISR                (ISR),
        .Rotate             (Rotate),
        .lowest_priority    (lowest_priority),
        .highest_in_service (highest_in_service),
        .in_service_valid   (in_service_valid),
        .vector_level       (vector_level),
        .spurious           (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the currently driven inputs for one clock, then drop the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        INTA_1  = 1'b0;
        INTA_2  = 1'b0;
        OCW2_WR = 1'b0;
        ISR_IRR = 8'h00;
    endtask

    task automatic inta1(input logic [7:0] irr);
        INTA_1  = 1'b1;
        ISR_IRR = irr;
        tick();
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] l);
        OCW2_WR  = 1'b1;
        OCW2_CMD = cmd;
        OCW2_L   = l;
        tick();
    endtask

    initial begin
        reset = 1'b1; INTA_1 = 1'b0; INTA_2 = 1'b0; AEOI = 1'b0; OCW2_WR = 1'b0;
        ISR_IRR = 8'h00; OCW2_CMD = 3'b010; OCW2_L = 3'd0;
        #2;
        chk("rst_isr", ISR, 8'h00);
        chk("rst_rotate", {5'd0, Rotate}, 8'h02);
        chk("rst_lowest", {5'd0, lowest_priority}, 8'h07);
        chk("rst_vector", {5'd0, vector_level}, 8'h07);
        chk("rst_spurious", {7'd0, spurious}, 8'h00);
        chk("rst_valid", {7'd0, in_service_valid}, 8'h00);
        chk("rst_hs", {5'd0, highest_in_service}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        inta1(8'h10);
        chk("grant10_isr", ISR, 8'h10);
        chk("grant10_vec", {5'd0, vector_level}, 8'h04);
        chk("grant10_spur", {7'd0, spurious}, 8'h00);
        chk("grant10_valid", {7'd0, in_service_valid}, 8'h01);
        ocw2(3'b001, 3'd0);
        chk("nseoi_isr", ISR, 8'h00);
        chk("nseoi_rotate", {5'd0, Rotate}, 8'h02);

        inta1(8'h50);
        chk("multihot_isr", ISR, 8'h10);
        chk("multihot_vec", {5'd0, vector_level}, 8'h04);
        ocw2(3'b001, 3'd0);

        inta1(8'h20);
        inta1(8'h02);
        chk("nest_isr", ISR, 8'h22);
        chk("nest_hs", {5'd0, highest_in_service}, 8'h01);
        ocw2(3'b001, 3'd0);
        chk("nest_eoi_isr", ISR, 8'h20);
        ocw2(3'b011, 3'd5);
        chk("speoi_isr", ISR, 8'h00);

        ocw2(3'b110, 3'd3);
        chk("setpri_lowest", {5'd0, lowest_priority}, 8'h03);
        chk("setpri_rotate", {5'd0, Rotate}, 8'h02);
        inta1(8'h80);
        inta1(8'h01);
        chk("wrap_isr", ISR, 8'h81);
        chk("wrap_hs", {5'd0, highest_in_service}, 8'h07);
        ocw2(3'b101, 3'd0);
        chk("rotns_isr", ISR, 8'h01);
        chk("rotns_lowest", {5'd0, lowest_priority}, 8'h07);
        chk("rotns_rotate", {5'd0, Rotate}, 8'h05);
        ocw2(3'b001, 3'd0);
        chk("clear0_isr", ISR, 8'h00);

        AEOI = 1'b1;
        ocw2(3'b100, 3'd0);
        chk("aeoiset_rotate", {5'd0, Rotate}, 8'h04);
        inta1(8'h08);
        chk("aeoi_grant_isr", ISR, 8'h08);
        INTA_2 = 1'b1; tick();
        chk("aeoi_isr", ISR, 8'h00);
        chk("aeoi_lowest", {5'd0, lowest_priority}, 8'h03);

        inta1(8'h40);
        inta1(8'h00);
        chk("spur_flag", {7'd0, spurious}, 8'h01);
        chk("spur_vec", {5'd0, vector_level}, 8'h07);
        chk("spur_isr", ISR, 8'h40);
        INTA_2 = 1'b1; tick();
        chk("spur_inta2_isr", ISR, 8'h40);

        AEOI = 1'b0;
        ocw2(3'b011, 3'd6);
        chk("speoi6_isr", ISR, 8'h00);
        inta1(8'h04);
        INTA_2 = 1'b1; tick();
        chk("noaeoi_inta2_isr", ISR, 8'h04);

        INTA_1 = 1'b1; ISR_IRR = 8'h04;
        OCW2_WR = 1'b1; OCW2_CMD = 3'b011; OCW2_L = 3'd2;
        tick();
        chk("setwins_isr", ISR, 8'h04);

        AEOI = 1'b1;
        INTA_1 = 1'b1; INTA_2 = 1'b1; ISR_IRR = 8'h20;
        tick();
        chk("both_inta_isr", ISR, 8'h24);
        chk("both_inta_vec", {5'd0, vector_level}, 8'h05);
        INTA_2 = 1'b1; tick();
        chk("aeoi5_isr", ISR, 8'h04);
        chk("aeoi5_lowest", {5'd0, lowest_priority}, 8'h05);
        chk("aeoi5_hs", {5'd0, highest_in_service}, 8'h02);

        ocw2(3'b000, 3'd0);
        chk("aeoiclr_rotate", {5'd0, Rotate}, 8'h00);
        ocw2(3'b100, 3'd0);
        inta1(8'h02);
        chk("pre_conflict_isr", ISR, 8'h06);
        INTA_2 = 1'b1;
        OCW2_WR = 1'b1; OCW2_CMD = 3'b110; OCW2_L = 3'd4;
        tick();
        chk("conflict_isr", ISR, 8'h04);
        chk("conflict_lowest", {5'd0, lowest_priority}, 8'h04);

        #1 reset = 1'b1;
        #1;
        chk("async_isr", ISR, 8'h00);
        chk("async_lowest", {5'd0, lowest_priority}, 8'h07);
        chk("async_rotate", {5'd0, Rotate}, 8'h02);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        INTA_2 = 1'b1; tick();
        chk("post_rst_inta2_isr", ISR, 8'h00);
        chk("post_rst_inta2_lowest", {5'd0, lowest_priority}, 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/in_service_register.md
Name: in_service_register

Overview:
- Downstream stage of the priority resolver in the 8259A PIC.
- Captures the one-hot grant (ISR_IRR) on the first INTA pulse into the In-Service Register (ISR).
- Clears ISR bits on EOI commands (OCW2) or automatically on the second INTA pulse in AEOI mode.
- Holds the rotating-priority state (lowest-priority level and last rotate code) that the resolver and control logic consume.

Parameters:
- RESET_LOWEST, 3'd7, lowest-priority level after reset; IR0 is then highest.
- RESET_ROTATE, 3'b010, Rotate code after reset (OCW2 no-op).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- INTA_1  in  1  one-cycle strobe, first INTA pulse (from control)
- INTA_2  in  1  one-cycle strobe, second INTA pulse (from control)
- ISR_IRR  in  8  one-hot grant from priority resolver; 0 = none
- AEOI  in  1  auto-EOI mode (ICW4 bit), static level
- OCW2_WR  in  1  one-cycle strobe, OCW2 written
- OCW2_CMD  in  3  OCW2 {R,SL,EOI}
- OCW2_L  in  3  OCW2 level field L2..L0
- ISR  out  8  in-service register
- Rotate  out  3  last rotate-relevant OCW2 code (to resolver)
- lowest_priority  out  3  current lowest-priority level
- highest_in_service  out  3  highest-priority set ISR level (rotation-aware)
- in_service_valid  out  1  ISR != 0
- vector_level  out  3  level captured at INTA_1 (to control, for vector byte)
- spurious  out  1  INTA_1 arrived with ISR_IRR == 0

Behaviour:
- Reset (async, immediate): ISR=0, Rotate=RESET_ROTATE, lowest_priority=RESET_LOWEST, vector_level=3'd7, spurious=0, in_service_valid=0, highest_in_service=0.
- All outputs registered except highest_in_service and in_service_valid, which are combinational from ISR/lowest_priority.
- Register updates take effect one cycle after the strobe.
- Priority order: (lowest_priority+1) mod 8 is highest, wrapping through to lowest_priority.
- INTA_1:
  - vector_level <= encode(ISR_IRR); ISR <= ISR | ISR_IRR; spurious <= 0.
  - If ISR_IRR == 0: ISR unchanged, vector_level <= 7, spurious <= 1.
  - If ISR_IRR is not one-hot: treat as the lowest set index; no error.
- INTA_2 with AEOI=1:
  - Clear ISR[vector_level] unless spurious.
  - If Rotate == 3'b100: lowest_priority <= vector_level.
  - INTA_2 with AEOI=0: no state change.
- OCW2_WR decode on OCW2_CMD (clears use ISR value before this cycle's INTA_1 set):
  - 001 non-specific EOI: clear ISR[highest_in_service]; no-op if ISR==0.
  - 101 rotate on NS EOI: as 001, and lowest_priority <= cleared level; priorities unchanged if ISR==0.
  - 011 specific EOI: clear ISR[OCW2_L].
  - 111 rotate on specific EOI: clear ISR[OCW2_L]; lowest_priority <= OCW2_L.
  - 110 set priority: lowest_priority <= OCW2_L; ISR unchanged.
  - 100 / 000: rotate-in-AEOI set / clear; Rotate <= code only.
  - 010: no-op.
  - Rotate <= OCW2_CMD for codes 101, 100, 111, 000; other codes leave Rotate unchanged.
- Simultaneous events:
  - INTA_1 + OCW2 clear in the same cycle: both apply; a set of the same bit wins.
  - INTA_2 AEOI clear + OCW2 clear: both clears OR'd.
  - Conflicting lowest_priority writes: OCW2 wins over AEOI rotate.
  - INTA_1 and INTA_2 asserted together: protocol error; INTA_1 processed, INTA_2 ignored.
- Nesting: multiple ISR bits may be set. highest_in_service wraps through level 7 to 0 relative to lowest_priority.
- Reset mid-sequence (between INTA_1 and INTA_2): everything returns to reset values; a later INTA_2 clears nothing because spurious=0 and ISR=0.

Decomposition:
- Shared package pic_pkg:
  - OCW2 code constants: OCW2_NS_EOI=3'b001, OCW2_SP_EOI=3'b011, OCW2_ROT_NS_EOI=3'b101, OCW2_ROT_AEOI_SET=3'b100, OCW2_ROT_AEOI_CLR=3'b000, OCW2_ROT_SP_EOI=3'b111, OCW2_SET_PRI=3'b110, OCW2_NOP=3'b010.
  - 3-bit level typedef.
- One sub-module: isr_priority_scan.
  - Combinational rotating find-first-set over 8 bits given lowest_priority.
  - Outputs level and valid.
  - Reused later by the resolver.

Test Plan:
- Reset, then INTA_1 with ISR_IRR=8'h10 -> next cycle ISR=8'h10, vector_level=4, spurious=0; OCW2 001 -> ISR=8'h00.
- Nested: INTA_1 grant 8'h20, then INTA_1 grant 8'h02 -> ISR=8'h22, highest_in_service=1; OCW2 001 -> ISR=8'h20.
- OCW2 110 L=3 -> lowest_priority=3; ISR=8'h81 -> highest_in_service=7; OCW2 101 -> ISR=8'h01, lowest_priority=7.
- AEOI=1, OCW2 100, INTA_1 grant 8'h08, INTA_2 -> ISR=8'h00, lowest_priority=3, Rotate=3'b100.
- INTA_1 with ISR_IRR=0 -> spurious=1, vector_level=7, ISR unchanged; AEOI INTA_2 -> ISR unchanged.
- Same-cycle INTA_1 grant 8'h04 and OCW2 011 L=2 with ISR=8'h04 beforehand -> ISR stays 8'h04; async reset pulse mid-cycle -> ISR=0 before next clk edge.
